// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and the fetch-entry type
package pipe_pkg;

  localparam int INSTQ_DEPTH = 4;
  localparam int PIPE_AW     = 32;
  localparam int PIPE_DW     = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PIPE_AW-1:0] pc;
    logic [PIPE_DW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/pipe_inst_queue_mem.sv
// rtl/pipe_inst_queue_mem.sv - DEPTH x W register array, sync write, async read, sync clear
module pipe_inst_queue_mem
  import pipe_pkg::*;
#(
  parameter int DEPTH = INSTQ_DEPTH,
  parameter int W     = PIPE_AW + PIPE_DW,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_inst_queue.sv
// rtl/pipe_inst_queue.sv - IF/ID decoupling instruction queue; INSTQ_BYPASS_EN enables empty fall-through
module pipe_inst_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = INSTQ_DEPTH,
  parameter int AW    = PIPE_AW,
  parameter int DW    = PIPE_DW
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [AW-1:0]            pc_in,
  input  logic [DW-1:0]            inst_in,
  output logic                     full,
  input  logic                     rd_en,
  output logic                     valid,
  output logic [AW-1:0]            pc_out,
  output logic [DW-1:0]            inst_out,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             stored_v, byp, do_wr, do_rd;
  logic [AW+DW-1:0] head;

  assign count    = count_q;
  assign full     = (count_q == FULL_CNT);
  assign stored_v = (count_q != '0);

`ifdef INSTQ_BYPASS_EN
  assign byp = (count_q == '0) && wr_en && !flush && !clr;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry that is consumed in the same cycle is never stored.
  assign do_wr = wr_en && !full && !(byp && rd_en);
  assign do_rd = rd_en && stored_v;
  assign valid = stored_v || byp;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (do_wr) wp_d = wp_q + PW'(1);
      if (do_rd) rp_d = rp_q + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  pipe_inst_queue_mem #(
    .DEPTH (DEPTH),
    .W     (AW + DW),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .clr_i   (clr),
    .we_i    (do_wr && !flush),
    .waddr_i (wp_q),
    .wdata_i ({pc_in, inst_in}),
    .raddr_i (rp_q),
    .rdata_o (head)
  );

  always_comb begin
    pc_out   = '0;
    inst_out = DW'(NOP);
    if (byp) begin
      pc_out   = pc_in;
      inst_out = inst_in;
    end else if (stored_v) begin
      {pc_out, inst_out} = head;
    end
  end

endmodule

// File: tb/tb_pipe_inst_queue.sv
// tb/tb_pipe_inst_queue.sv - scoreboard bench for pipe_inst_queue with directed and random stimulus
module tb_pipe_inst_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
`ifdef INSTQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, wr_en, rd_en, flush;
  logic [31:0] pc_in, inst_in;
  logic        full, valid;
  logic [31:0] pc_out, inst_out;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  fetch_entry_t exp_q[$];
  int           m_cnt = 0;

  pipe_inst_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (wr_en),
    .pc_in    (pc_in),
    .inst_in  (inst_in),
    .full     (full),
    .rd_en    (rd_en),
    .valid    (valid),
    .pc_out   (pc_out),
    .inst_out (inst_out),
    .flush    (flush),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: occupancy and accepted-entry order, updated at each edge.
  initial forever begin
    bit byp, rd, wr;
    @(posedge clk);
    if (clr || flush) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      byp = BYP && (m_cnt == 0) && wr_en;
      rd  = rd_en && (m_cnt > 0);
      wr  = wr_en && (m_cnt < DEPTH) && !(byp && rd_en);
      if (wr) exp_q.push_back('{pc: pc_in, inst: inst_in});
      m_cnt = m_cnt + int'(wr) - int'(rd);
    end
  end

  // Monitor: checks flags every cycle, compares and retires the head on each read.
  initial forever begin
    bit           byp_now;
    fetch_entry_t e;
    @(negedge clk);
    if (run) begin
      byp_now = BYP && (m_cnt == 0) && wr_en && !flush && !clr;
      chk("count", 32'(count), 32'(m_cnt));
      chk("full",  32'(full),  32'(m_cnt == DEPTH));
      chk("valid", 32'(valid), 32'((m_cnt != 0) || byp_now));
      if (byp_now) begin
        chk("bypass_pc",   pc_out,   pc_in);
        chk("bypass_inst", inst_out, inst_in);
      end else if (m_cnt > 0 && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("head_pc",   pc_out,   e.pc);
        chk("head_inst", inst_out, e.inst);
        if (rd_en && !flush && !clr) void'(exp_q.pop_front());
      end else begin
        chk("idle_pc",   pc_out,   32'h0);
        chk("idle_inst", inst_out, NOP);
      end
    end
  end

  task automatic cyc(input bit c, input bit f, input bit w, input bit r, input logic [31:0] pc);
    clr     = c;
    flush   = f;
    wr_en   = w;
    rd_en   = r;
    pc_in   = pc;
    inst_in = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    pc_in = '0; inst_in = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 1, 0, 32'h40);
    run = 1'b1;
    cyc(1, 0, 1, 0, 32'h40);
    cyc(0, 0, 0, 0, 32'h0);

    // fill, refused fifth write, drain, refill across wrap
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 32'(i * 4));
    cyc(0, 0, 1, 0, 32'h10);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 0, 32'h100);
    cyc(0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'(32'h200 + i * 4));

    // count=2 then simultaneous read/write
    cyc(0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 32'(32'h300 + i * 4));

    // full with simultaneous read/write, then flush priority at count=3
    cyc(0, 0, 1, 0, 32'h400);
    cyc(0, 0, 1, 0, 32'h404);
    cyc(0, 0, 1, 1, 32'h408);
    cyc(0, 1, 1, 1, 32'h20);
    cyc(0, 0, 0, 0, 32'h0);

    // empty-queue write, with and without a same-cycle read
    cyc(0, 0, 1, 0, 32'h80);
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 1, 1, 32'h84);
    cyc(0, 0, 0, 1, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
          {$urandom_range(0, 32'h3fff_ffff), 2'b00});
    end

    cyc(0, 0, 0, 0, 32'h0);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_inst_queue.md
# pipe_inst_queue

Decoupling instruction queue between the IF stage and the ID stage of the pipelined CPU. It buffers up to DEPTH fetched {pc, inst} pairs so that a decode stall no longer freezes the PC immediately. The IF stage drives `IFwip = ~full`. On a taken branch or jump, `flush` discards every buffered entry.

## Interface
- DEPTH, 4: number of queue entries; must be a power of two, at least 2.
- AW, 32: PC width.
- DW, 32: instruction width.

- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high. Sampled on the rising edge of clk.
- wr_en  in  1  IF presents a valid fetched instruction this cycle.
- pc_in  in  AW  PC of the incoming instruction.
- inst_in  in  DW  incoming instruction word.
- full  out  1  queue holds DEPTH entries; writes are refused.
- rd_en  in  1  ID consumes the head entry this cycle.
- valid  out  1  head entry present on pc_out/inst_out.
- pc_out  out  AW  PC of the head entry; 0 when !valid.
- inst_out  out  DW  head instruction; 32'h0000_0000 (NOP) when !valid.
- flush  in  1  discard all entries (taken branch/jump).
- count  out  $clog2(DEPTH)+1  number of stored entries.

## Operation
- Circular buffer with write pointer wp, read pointer rp and occupancy count. Pointers wrap modulo DEPTH.
- Write accepted when `wr_en && !full`. A write while full is ignored; IF is stalled through IFwip.
- Read accepted when `rd_en && valid`. A read while empty is ignored, and no pointer moves.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- full is never relieved by a same-cycle read. A write while full is refused even if rd_en=1.
- Priority per cycle: clr, then flush, then read/write.
- flush: wp=rp=0, count=0. A same-cycle wr_en and rd_en are both discarded.
- clr: identical to flush. It also zeroes the storage array, so no stale data can reach the outputs.
- Outputs are driven from the head entry and masked to 0 / NOP when count==0 (see INSTQ_BYPASS_EN for the one exception).
- full = (count==DEPTH). valid = (count!=0), or bypass per Configuration.

## Timing
- Reset values: full=0, valid=0, count=0, pc_out=0, inst_out=0.
- Write-to-valid latency without bypass: 1 cycle. An entry written at edge N is visible after edge N.
- Read: the head advances at the consuming edge. The next entry is visible in the following cycle with no bubble.
- flush asserted in cycle N: valid=0 and count=0 after edge N. A write in cycle N+1 is visible after edge N+1.
- full deasserts the cycle after the first read from a full queue. IFwip follows combinationally.
- Sustained throughput: 1 entry/cycle when both sides are enabled and the queue is neither full nor empty.

## Configuration
- Macro: `INSTQ_BYPASS_EN`.
- Defined: fall-through when empty.
  - When count==0 and wr_en=1, valid=1 and pc_out/inst_out equal pc_in/inst_in combinationally in the same cycle.
  - If rd_en=1 in that cycle as well, the entry is consumed without being stored: count stays 0 and the pointers do not move.
  - flush or clr suppresses the bypass: valid=0.
- Undefined: no combinational path from the inputs to valid/pc_out/inst_out. All outputs come from stored state, with the 1-cycle write latency.

## Structure
- Shared package `pipe_pkg` holds:
  - NOP constant 32'h0000_0000;
  - the fetch-entry typedef {pc[AW-1:0], inst[DW-1:0]};
  - the default DEPTH.
- One sub-module: `pipe_inst_queue_mem`, a DEPTH×(AW+DW) register array.
  - Synchronous write port; asynchronous read at rp.
  - Synchronous clear on clr.
- Pointer, count and flag logic stay in the top module.

## Test plan
- Reset: hold clr=1 for 2 cycles with wr_en=1 and pc_in=0x40 → after release full=0, valid=0, count=0, pc_out=0, inst_out=0.
- Fill/stall: write pc 0x00, 0x04, 0x08, 0x0C with rd_en=0 → count=4 and full=1. A fifth write with pc 0x10 is refused, and the head stays pc 0x00.
- Drain order and wrap: read 4 entries → pc_out sequence 0x00, 0x04, 0x08, 0x0C, then valid=0 and inst_out=0. Refill 3 entries → head pc is correct across pointer wrap.
- Simultaneous read and write:
  - At count=2, with wr_en=rd_en=1 for 5 cycles → count stays 2, and output order matches input order.
  - At count=4 (full), with wr_en=rd_en=1 → read accepted, write refused, count=3.
- Flush priority: at count=3, assert flush with wr_en=1 (pc 0x20) and rd_en=1 → count=0 and valid=0 next cycle; pc 0x20 is not stored.
- Bypass (INSTQ_BYPASS_EN defined): queue empty, wr_en=1 with pc 0x80 / inst 0x2002_0005 → valid=1 in the same cycle with those values. With rd_en=1, count stays 0. With the macro undefined, valid rises one cycle later.
